// File: rtl/spi_gpio_expander.sv
// spi_gpio_expander: SPI-mode-0 slave bridging 16-bit frames (R/W, 7-bit
// address, 8 data bits) onto per-bank DIR/OUT/IN registers that control
// BANK_NUM x PDATA_WIDTH bidirectional GPIO pads.
module spi_gpio_expander #(
    parameter int BANK_NUM    = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int PDATA_WIDTH = 8,
    parameter int ADDR_WIDTH  = 7,
    parameter int PADDR_WIDTH = 3
) (
    input  logic                            sclk,
    input  logic                            resetn,
    input  logic                            ss,
    input  logic                            mosi,
    output logic                            miso,
    inout  wire  [BANK_NUM*PDATA_WIDTH-1:0] pad
);

    localparam int PAD_W = BANK_NUM * PDATA_WIDTH;

    // Frame state: cleared by ss high (framing) or resetn (sync reset)
    logic [4:0]              cnt_r;
    logic [DATA_WIDTH-2:0]   sh_r;
    logic [PDATA_WIDTH-1:0]  rd_sh_r;

    // Register file, one DIR/OUT pair per bank
    logic [PDATA_WIDTH-1:0]  dir_r [BANK_NUM];
    logic [PDATA_WIDTH-1:0]  out_r [BANK_NUM];

    logic [PAD_W-1:0]        pad_in_s;
    logic [PAD_W-1:0]        pad_oe_s;
    logic [PAD_W-1:0]        pad_o_s;
    logic [ADDR_WIDTH-1:0]   hdr_addr_s;
    logic [DATA_WIDTH-1:0]   frame_s;
    logic [ADDR_WIDTH-1:0]   frame_addr_s;
    logic [PDATA_WIDTH-1:0]  frame_data_s;
    logic [PDATA_WIDTH-1:0]  rd_val_s;
    logic                    wr_en_s;

    // Address hit for bank b: bank field equals b+1 and the gap bits are zero
    function automatic logic bank_hit(input logic [ADDR_WIDTH-1:0] a, input int b);
        logic [1:0] bank_field;
        bank_field = a[ADDR_WIDTH-1:ADDR_WIDTH-2];
        return (a[ADDR_WIDTH-3:PADDR_WIDTH] == '0) && (int'(bank_field) == (b + 1));
    endfunction

    assign pad_in_s = pad;

    // The header is complete on the 8th edge, using the bit arriving at that edge
    assign hdr_addr_s   = {sh_r[ADDR_WIDTH-2:0], mosi};
    assign frame_s      = {sh_r, mosi};
    assign frame_addr_s = frame_s[DATA_WIDTH-2:PDATA_WIDTH];
    assign frame_data_s = frame_s[PDATA_WIDTH-1:0];
    assign wr_en_s      = (cnt_r == 5'd15) && !ss && frame_s[DATA_WIDTH-1];

    assign miso = rd_sh_r[PDATA_WIDTH-1];

    // Read-data mux for the header address; unmapped and reserved read as zero
    always_comb begin
        rd_val_s = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (bank_hit(hdr_addr_s, b)) begin
                case (hdr_addr_s[PADDR_WIDTH-1:0])
                    3'd0:    rd_val_s = dir_r[b];
                    3'd1:    rd_val_s = out_r[b];
                    3'd2:    rd_val_s = pad_in_s[b*PDATA_WIDTH +: PDATA_WIDTH];
                    default: rd_val_s = '0;
                endcase
            end else begin
                rd_val_s = rd_val_s;
            end
        end
    end

    // Bit counter, mosi shifter and miso shifter; edges past 16 are ignored
    always_ff @(posedge sclk or posedge ss) begin
        if (ss) begin
            cnt_r   <= 5'd0;
            sh_r    <= '0;
            rd_sh_r <= '0;
        end else if (resetn) begin
            cnt_r   <= 5'd0;
            sh_r    <= '0;
            rd_sh_r <= '0;
        end else if (cnt_r != 5'd16) begin
            cnt_r <= cnt_r + 5'd1;
            sh_r  <= {sh_r[DATA_WIDTH-3:0], mosi};
            if (cnt_r == 5'd7) begin
                rd_sh_r <= rd_val_s;
            end else begin
                rd_sh_r <= {rd_sh_r[PDATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // DIR/OUT registers: synchronous reset, commit on the 16th edge of a write
    always_ff @(posedge sclk) begin
        if (resetn) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                dir_r[b] <= '0;
                out_r[b] <= '0;
            end
        end else if (wr_en_s) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                if (bank_hit(frame_addr_s, b)) begin
                    case (frame_addr_s[PADDR_WIDTH-1:0])
                        3'd0:    dir_r[b] <= frame_data_s;
                        3'd1:    out_r[b] <= frame_data_s;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Flatten per-bank registers into pad enable/value vectors
    always_comb begin
        pad_oe_s = '0;
        pad_o_s  = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            pad_oe_s[b*PDATA_WIDTH +: PDATA_WIDTH] = dir_r[b];
            pad_o_s[b*PDATA_WIDTH +: PDATA_WIDTH]  = out_r[b];
        end
    end

    for (genvar i = 0; i < PAD_W; i++) begin : g_pad
        assign pad[i] = pad_oe_s[i] ? pad_o_s[i] : 1'bz;
    end

endmodule

// File: tb/tb_spi_gpio_expander.sv
// Directed bench for spi_gpio_expander: SPI frames driven by tasks, read
// expectations queued on issue and compared when the frame completes.
module tb_spi_gpio_expander;

    logic        sclk   = 1'b0;
    logic        resetn = 1'b1;
    logic        ss     = 1'b1;
    logic        mosi   = 1'b0;
    wire         miso;
    wire  [15:0] pad;

    logic [15:0] drv_en  = 16'h0000;
    logic [15:0] drv_val = 16'h0000;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  dummy;

    for (genvar gi = 0; gi < 16; gi++) begin : g_drv
        assign pad[gi] = drv_en[gi] ? drv_val[gi] : 1'bz;
    end

    spi_gpio_expander dut (
        .sclk   (sclk),
        .resetn (resetn),
        .ss     (ss),
        .mosi   (mosi),
        .miso   (miso),
        .pad    (pad)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one frame of nedges bits (bits after 16 are ones); capture miso
    task automatic frame(input logic [15:0] f, input int nedges, output logic [7:0] rd);
        rd = 8'h00;
        for (int n = 1; n <= nedges; n++) begin
            @(negedge sclk);
            ss   = 1'b0;
            mosi = (n <= 16) ? f[16-n] : 1'b1;
            @(posedge sclk);
            #2;
            if (n >= 8 && n <= 15) rd[15-n] = miso;
            else check("miso_idle", {15'd0, miso}, 16'h0000);
        end
        @(negedge sclk);
        ss   = 1'b1;
        mosi = 1'b0;
        #1;
        check("miso_ss_high", {15'd0, miso}, 16'h0000);
    endtask

    task automatic wr(input logic [15:0] f);
        logic [7:0] d;
        frame(f, 16, d);
    endtask

    task automatic rd(input logic [6:0] addr, input logic [7:0] exp, input string tag);
        logic [7:0] got;
        logic [7:0] e;
        exp_q.push_back(exp);
        frame({1'b0, addr, 8'h00}, 16, got);
        e = exp_q.pop_front();
        check(tag, {8'h00, got}, {8'h00, e});
    endtask

    initial begin
        // Reset
        @(negedge sclk);
        resetn = 1'b1;
        repeat (2) @(negedge sclk);
        resetn = 1'b0;
        #1;
        check("miso_after_reset", {15'd0, miso}, 16'h0000);
        rd(7'h20, 8'h00, "dir0_reset");
        rd(7'h21, 8'h00, "out0_reset");
        rd(7'h40, 8'h00, "dir1_reset");

        // All pads released after reset: bench-driven levels read back
        drv_en = 16'hFFFF; drv_val = 16'h5AC3;
        rd(7'h22, 8'hC3, "in0_hiz_reset");
        rd(7'h42, 8'h5A, "in1_hiz_reset");
        drv_en = 16'h0000;

        // Bank0 all outputs driving zero, bank1 still Hi-Z
        wr(16'hA0FF);
        check("pad0_driven_zero", {8'h00, pad[7:0]}, 16'h0000);
        drv_en = 16'hFF00; drv_val = 16'h9600;
        rd(7'h42, 8'h96, "in1_still_hiz");
        drv_en = 16'h0000;
        rd(7'h20, 8'hFF, "read_dir0");
        rd(7'h21, 8'h00, "out0_unchanged");

        // Bank1 output pattern
        wr(16'hC0FF);
        wr(16'hC1A5);
        check("pad1_a5", {8'h00, pad[15:8]}, 16'h00A5);
        rd(7'h41, 8'hA5, "read_out1");
        rd(7'h42, 8'hA5, "in1_reflects_out");

        // Bank0 as input with external pattern
        wr(16'hA000);
        drv_en = 16'h00FF; drv_val = 16'h003C;
        rd(7'h22, 8'h3C, "in0_3c");
        drv_en = 16'h0000;

        // Aborted frames perform no write
        frame(16'hC15A, 10, dummy);
        check("abort_pad1", {8'h00, pad[15:8]}, 16'h00A5);
        frame(16'hA17E, 10, dummy);
        rd(7'h21, 8'h00, "abort_out0");

        // Unmapped / reserved / read-only targets
        wr(16'hE0FF);
        rd(7'h60, 8'h00, "unmapped_60");
        check("unmapped_pad1", {8'h00, pad[15:8]}, 16'h00A5);
        rd(7'h20, 8'h00, "unmapped_60_dir0");
        wr(16'hA8FF);
        rd(7'h28, 8'h00, "unmapped_28");
        rd(7'h20, 8'h00, "unmapped_28_dir0");
        wr(16'hA3FF);
        rd(7'h23, 8'h00, "reserved_23");
        wr(16'h80FF);
        rd(7'h00, 8'h00, "unmapped_00");
        wr(16'hC2FF);
        rd(7'h42, 8'hA5, "in_write_ignored");
        rd(7'h41, 8'hA5, "out1_after_in_write");

        // Extra edges after bit 16 are ignored
        frame(16'hC155, 24, dummy);
        check("overlong_pad1", {8'h00, pad[15:8]}, 16'h0055);
        rd(7'h41, 8'h55, "overlong_out1");

        // Second reset clears registers
        @(negedge sclk);
        resetn = 1'b1;
        @(negedge sclk);
        resetn = 1'b0;
        rd(7'h40, 8'h00, "dir1_reset2");
        rd(7'h41, 8'h00, "out1_reset2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
